// File: rtl/mcu_seq.sv
// -----------------------------------------------------------------------------
// mcu_seq -- column sequencer in front of the MCU controller (2D convolution).
//
// Runs a frame one column at a time: host pixel loads, convolution processing
// and result readout. Drives the {eop,sop} state code and the change-block
// pulse that the MCU controller consumes, and the row address into the
// column memories.
//
// State code {o_eop,o_sop}: LOAD/FILL = 00, PROC = 01, OUT = 10, IDLE/DONE = 11.
// Frame flow: IDLE -> FILL -> PROC -> OUT -> {LOAD -> PROC -> OUT}* -> DONE -> IDLE
//
// Parameters
//   N         kernel span - 1; FILL loads N+1 columns before the first PROC
//   ADDR_W    width of row address, column length and column count
//   PROC_LAT  extra PROC cycles spent holding the last row address
//
// Ports
//   clk         in   1       clock, rising edge
//   rst         in   1       synchronous active-low reset
//   i_start     in   1       frame start pulse (accepted only in IDLE, valid config)
//   i_img_cols  in   ADDR_W  image columns, latched on accepted start
//   i_col_len   in   ADDR_W  rows per column, latched on accepted start
//   i_wr_valid  in   1       host pixel valid
//   o_wr_ready  out  1       ready for host pixel (FILL/LOAD)
//   i_rd_ready  in   1       downstream ready for result pixel
//   o_rd_valid  out  1       result pixel at o_addr valid (OUT)
//   o_sop       out  1       state code bit 0
//   o_eop       out  1       state code bit 1
//   o_chblk     out  1       one-cycle pulse after each completed column
//   o_addr      out  ADDR_W  row address into column memories
//   o_busy      out  1       frame in progress
//   o_done      out  1       one-cycle pulse at end of frame
// -----------------------------------------------------------------------------
module mcu_seq #(
    parameter int N        = 2,
    parameter int ADDR_W   = 10,
    parameter int PROC_LAT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_start,
    input  logic [ADDR_W-1:0] i_img_cols,
    input  logic [ADDR_W-1:0] i_col_len,
    input  logic              i_wr_valid,
    output logic              o_wr_ready,
    input  logic              i_rd_ready,
    output logic              o_rd_valid,
    output logic              o_sop,
    output logic              o_eop,
    output logic              o_chblk,
    output logic [ADDR_W-1:0] o_addr,
    output logic              o_busy,
    output logic              o_done
);

    localparam int LAT_W = (PROC_LAT < 1) ? 1 : $clog2(PROC_LAT + 1);

    localparam logic [LAT_W-1:0]  LAT_LAST  = LAT_W'(PROC_LAT);
    localparam logic [ADDR_W-1:0] MIN_COLS  = ADDR_W'(N + 1);
    // FILL is done once the column about to complete is column index N.
    localparam logic [ADDR_W-1:0] FILL_LAST = ADDR_W'(N);

    localparam logic [1:0] CODE_LOAD = 2'b00;
    localparam logic [1:0] CODE_PROC = 2'b01;
    localparam logic [1:0] CODE_OUT  = 2'b10;
    localparam logic [1:0] CODE_IDLE = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_PROC,
        S_OUT,
        S_LOAD,
        S_DONE
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] cfg_cols;
    logic [ADDR_W-1:0] cfg_len;
    logic [ADDR_W-1:0] loaded_cols;   // columns written into the MCU this frame
    logic [ADDR_W-1:0] out_cols;      // result columns read out this frame
    logic [LAT_W-1:0]  lat_cnt;       // PROC cycles spent on the last row

    logic [ADDR_W-1:0] last_row;
    logic              at_last_row;

    // cfg_len is never 0 while a frame runs, so last_row cannot underflow there.
    assign last_row    = cfg_len - ADDR_W'(1);
    assign at_last_row = (o_addr == last_row);

    always_ff @(posedge clk) begin
        // NOTE: reset is synchronous, so it is tested inside the clocked block and
        // only takes effect at a rising edge; all state updates use <= so every
        // register sees the values from before this edge.
        if (!rst) begin
            state          <= S_IDLE;
            cfg_cols       <= '0;
            cfg_len        <= '0;
            loaded_cols    <= '0;
            out_cols       <= '0;
            lat_cnt        <= '0;
            o_addr         <= '0;
            {o_eop, o_sop} <= CODE_IDLE;
            o_wr_ready     <= 1'b0;
            o_rd_valid     <= 1'b0;
            o_chblk        <= 1'b0;
            o_busy         <= 1'b0;
            o_done         <= 1'b0;
        end else begin
            // NOTE: pulse outputs default low here so each branch only has to
            // raise them; they can never stick high for a second cycle.
            o_chblk <= 1'b0;
            o_done  <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (i_start && (i_img_cols >= MIN_COLS) && (i_col_len != '0)) begin
                        cfg_cols       <= i_img_cols;
                        cfg_len        <= i_col_len;
                        loaded_cols    <= '0;
                        out_cols       <= '0;
                        lat_cnt        <= '0;
                        o_addr         <= '0;
                        o_busy         <= 1'b1;
                        o_wr_ready     <= 1'b1;
                        {o_eop, o_sop} <= CODE_LOAD;
                        state          <= S_FILL;
                    end
                end

                // FILL and LOAD share the write path; they differ only in how many
                // columns they take before handing over to PROC.
                S_FILL, S_LOAD: begin
                    if (i_wr_valid) begin
                        if (at_last_row) begin
                            o_addr      <= '0;
                            o_chblk     <= 1'b1;
                            loaded_cols <= loaded_cols + ADDR_W'(1);
                            if ((state == S_LOAD) || (loaded_cols == FILL_LAST)) begin
                                lat_cnt        <= '0;
                                o_wr_ready     <= 1'b0;
                                {o_eop, o_sop} <= CODE_PROC;
                                state          <= S_PROC;
                            end
                        end else begin
                            o_addr <= o_addr + ADDR_W'(1);
                        end
                    end
                end

                // Sweep every row once, then sit on the last row while the
                // convolution pipeline drains.
                S_PROC: begin
                    if (!at_last_row) begin
                        o_addr <= o_addr + ADDR_W'(1);
                    end else if (lat_cnt == LAT_LAST) begin
                        lat_cnt        <= '0;
                        o_addr         <= '0;
                        o_rd_valid     <= 1'b1;
                        {o_eop, o_sop} <= CODE_OUT;
                        state          <= S_OUT;
                    end else begin
                        lat_cnt <= lat_cnt + LAT_W'(1);
                    end
                end

                S_OUT: begin
                    if (i_rd_ready) begin
                        if (at_last_row) begin
                            o_addr     <= '0;
                            o_chblk    <= 1'b1;
                            out_cols   <= out_cols + ADDR_W'(1);
                            o_rd_valid <= 1'b0;
                            if (loaded_cols < cfg_cols) begin
                                o_wr_ready     <= 1'b1;
                                {o_eop, o_sop} <= CODE_LOAD;
                                state          <= S_LOAD;
                            end else begin
                                o_busy         <= 1'b0;
                                o_done         <= 1'b1;
                                {o_eop, o_sop} <= CODE_IDLE;
                                state          <= S_DONE;
                            end
                        end else begin
                            o_addr <= o_addr + ADDR_W'(1);
                        end
                    end
                end

                S_DONE: begin
                    state <= S_IDLE;
                end

                default: begin
                    o_addr         <= '0;
                    o_wr_ready     <= 1'b0;
                    o_rd_valid     <= 1'b0;
                    o_busy         <= 1'b0;
                    {o_eop, o_sop} <= CODE_IDLE;
                    state          <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mcu_seq.sv
// -----------------------------------------------------------------------------
// tb_mcu_seq -- self-checking bench for mcu_seq (N=2, ADDR_W=10, PROC_LAT=4).
//
// A reference model expands each frame into the sequence of observable events
// (pixel writes, PROC cycles, result reads, chblk and done pulses, each with
// its row address) and queues them when the frame is started. A negedge
// monitor turns DUT activity into the same events and compares them in order.
// -----------------------------------------------------------------------------
module tb_mcu_seq;

    localparam int N        = 2;
    localparam int ADDR_W   = 10;
    localparam int PROC_LAT = 4;

    localparam int EV_WR   = 1;
    localparam int EV_RD   = 2;
    localparam int EV_PRC  = 3;
    localparam int EV_CHB  = 4;
    localparam int EV_DONE = 5;

    logic              clk = 1'b0;
    logic              rst;
    logic              i_start;
    logic [ADDR_W-1:0] i_img_cols;
    logic [ADDR_W-1:0] i_col_len;
    logic              i_wr_valid;
    logic              o_wr_ready;
    logic              i_rd_ready;
    logic              o_rd_valid;
    logic              o_sop;
    logic              o_eop;
    logic              o_chblk;
    logic [ADDR_W-1:0] o_addr;
    logic              o_busy;
    logic              o_done;

    mcu_seq #(
        .N        (N),
        .ADDR_W   (ADDR_W),
        .PROC_LAT (PROC_LAT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .i_start    (i_start),
        .i_img_cols (i_img_cols),
        .i_col_len  (i_col_len),
        .i_wr_valid (i_wr_valid),
        .o_wr_ready (o_wr_ready),
        .i_rd_ready (i_rd_ready),
        .o_rd_valid (o_rd_valid),
        .o_sop      (o_sop),
        .o_eop      (o_eop),
        .o_chblk    (o_chblk),
        .o_addr     (o_addr),
        .o_busy     (o_busy),
        .o_done     (o_done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    int exp_q[$];
    bit mon_en = 1'b0;
    int wr_cnt, chb_cnt, done_cnt, viol_cnt;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int ev(input int kind, input int addr);
        return kind * 65536 + addr;
    endfunction

    function automatic logic [1:0] code();
        return {o_eop, o_sop};
    endfunction

    // Expected event stream for one complete frame.
    task automatic push_frame(input int cols, input int len);
        int outs;
        outs = cols - N;
        for (int c = 0; c <= N; c++) begin
            for (int r = 0; r < len; r++) exp_q.push_back(ev(EV_WR, r));
            exp_q.push_back(ev(EV_CHB, 0));
        end
        for (int o = 0; o < outs; o++) begin
            if (o > 0) begin
                for (int r = 0; r < len; r++) exp_q.push_back(ev(EV_WR, r));
                exp_q.push_back(ev(EV_CHB, 0));
            end
            for (int p = 0; p < len + PROC_LAT; p++)
                exp_q.push_back(ev(EV_PRC, (p < len) ? p : len - 1));
            for (int r = 0; r < len; r++) exp_q.push_back(ev(EV_RD, r));
            exp_q.push_back(ev(EV_CHB, 0));
        end
        exp_q.push_back(ev(EV_DONE, 0));
    endtask

    task automatic emit(input int e);
        if (exp_q.size() == 0) check("extra_event", e, 0);
        else                   check("event", e, exp_q.pop_front());
    endtask

    // Monitor: same-cycle events are reported in the order chblk, done, then
    // the handshake/PROC activity of that cycle.
    always @(negedge clk) begin
        if ((o_wr_ready && o_rd_valid) ||
            (o_wr_ready && code() != 2'b00) ||
            (o_rd_valid && code() != 2'b10) ||
            (!o_busy && code() != 2'b11))
            viol_cnt++;
        if (mon_en && rst) begin
            if (o_chblk) begin
                chb_cnt++;
                emit(ev(EV_CHB, 0));
            end
            if (o_done) begin
                done_cnt++;
                emit(ev(EV_DONE, 0));
            end
            if (o_wr_ready && i_wr_valid) begin
                wr_cnt++;
                emit(ev(EV_WR, int'(o_addr)));
            end
            if (o_rd_valid && i_rd_ready) emit(ev(EV_RD, int'(o_addr)));
            if (code() == 2'b01)          emit(ev(EV_PRC, int'(o_addr)));
        end
    end

    task automatic pulse_start(input int cols, input int len);
        @(posedge clk); #1;
        i_start    = 1'b1;
        i_img_cols = ADDR_W'(cols);
        i_col_len  = ADDR_W'(len);
        @(posedge clk); #1;
        i_start    = 1'b0;
    endtask

    task automatic run_frame(input int cols, input int len, input bit bp, input bit poke);
        int  budget;
        int  cyc;
        bit  poked;
        budget   = 4 * (cols * len * 3 + cols * (PROC_LAT + 4)) + 200;
        wr_cnt   = 0;
        chb_cnt  = 0;
        done_cnt = 0;
        poked    = 1'b0;
        push_frame(cols, len);
        pulse_start(cols, len);
        cyc = 0;
        while (exp_q.size() > 0 && cyc < budget) begin
            @(posedge clk); #1;
            cyc++;
            if (bp) begin
                i_wr_valid = 1'($urandom_range(0, 1));
                i_rd_ready = 1'($urandom_range(0, 1));
            end
            if (poke && !poked && code() == 2'b01) begin
                i_start    = 1'b1;
                i_img_cols = ADDR_W'(7);
                i_col_len  = ADDR_W'(2);
                poked      = 1'b1;
            end else begin
                i_start = 1'b0;
            end
        end
        i_start    = 1'b0;
        i_wr_valid = 1'b1;
        i_rd_ready = 1'b1;
        check("drain", exp_q.size(), 0);
        exp_q.delete();
        repeat (6) @(negedge clk);
        check("busy_after", int'(o_busy), 0);
        check("code_after", int'(code()), 3);
        check("wr_count", wr_cnt, cols * len);
        check("chblk_count", chb_cnt, cols + (cols - N));
        check("done_count", done_cnt, 1);
    endtask

    function automatic int pack_outs();
        return int'({o_eop, o_sop, o_wr_ready, o_rd_valid, o_chblk, o_busy, o_done, o_addr});
    endfunction

    localparam int RESET_PACK = 3 << 15;

    initial begin
        rst        = 1'b0;
        i_start    = 1'b0;
        i_img_cols = '0;
        i_col_len  = '0;
        i_wr_valid = 1'b1;
        i_rd_ready = 1'b1;
        viol_cnt   = 0;

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outs", pack_outs(), RESET_PACK);
        @(posedge clk); #1;
        rst    = 1'b1;
        mon_en = 1'b1;

        // Reference frame, no backpressure, then the same frame with backpressure.
        run_frame(5, 4, 1'b0, 1'b0);
        run_frame(5, 4, 1'b1, 1'b0);

        // Invalid configurations: start must be ignored.
        pulse_start(2, 4);
        repeat (3) @(negedge clk);
        check("bad_cols_busy", int'(o_busy), 0);
        check("bad_cols_code", int'(code()), 3);
        pulse_start(5, 0);
        repeat (3) @(negedge clk);
        check("bad_len_busy", int'(o_busy), 0);
        check("bad_len_code", int'(code()), 3);

        // Start pulse during PROC is ignored; one done only.
        run_frame(5, 4, 1'b0, 1'b1);

        // Single-row columns, minimum column count.
        run_frame(3, 1, 1'b0, 1'b0);

        // Largest column length.
        run_frame(3, (1 << ADDR_W) - 1, 1'b0, 1'b0);

        // Reset held 3 cycles in the middle of OUT.
        mon_en = 1'b0;
        pulse_start(5, 4);
        for (int i = 0; i < 400 && code() != 2'b10; i++) @(negedge clk);
        check("reach_out", int'(code()), 2);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("midout_reset_outs", pack_outs(), RESET_PACK);
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check("post_reset_outs", pack_outs(), RESET_PACK);
        exp_q.delete();
        mon_en = 1'b1;

        // Recovery after abort, with backpressure.
        run_frame(4, 2, 1'b1, 1'b0);

        check("exclusive_outputs", viol_cnt, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
